// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner front end.
// Holds the window-scheduler state encoding and its default geometry.
package harris_pkg;

   localparam int COORD_W = 16;
   localparam int WIN     = 5;

   localparam int DEF_IMG_W   = 64;
   localparam int DEF_IMG_H   = 64;
   localparam int DEF_STEP    = 3;
   localparam int DEF_TIMEOUT = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      PRESENT,
      DRAIN,
      ADVANCE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/window_coord_gen.sv
// Next-window coordinate generator: strides the 5x5 window across the image,
// clamping the final stride so the last window sits flush with the image edge.
module window_coord_gen
   import harris_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int STEP  = DEF_STEP
) (
   input  logic [COORD_W-1:0] cur_x,
   input  logic [COORD_W-1:0] cur_y,
   output logic [COORD_W-1:0] step_x,
   output logic [COORD_W-1:0] step_y,
   output logic               wrap,
   output logic               last
);

   localparam logic [COORD_W:0] X_LIM    = (COORD_W+1)'(IMG_W - WIN);
   localparam logic [COORD_W:0] Y_LIM    = (COORD_W+1)'(IMG_H - WIN);
   localparam logic [COORD_W:0] STEP_EXT = (COORD_W+1)'(STEP);

   logic [COORD_W:0] x_sum;
   logic [COORD_W:0] y_sum;

   // One extra bit on the sums keeps a stride near the 16-bit ceiling from wrapping before the clamp.
   always_comb begin
      x_sum  = {1'b0, cur_x} + STEP_EXT;
      y_sum  = {1'b0, cur_y} + STEP_EXT;
      step_x = (x_sum > X_LIM) ? X_LIM[COORD_W-1:0] : x_sum[COORD_W-1:0];
      step_y = (y_sum > Y_LIM) ? Y_LIM[COORD_W-1:0] : y_sum[COORD_W-1:0];
      wrap   = ({1'b0, cur_x} >= X_LIM);
      last   = wrap && ({1'b0, cur_y} >= Y_LIM);
   end

endmodule

// File: rtl/sobel_window_scheduler.sv
// Walks 5x5 windows over a frame: fetch pixels, run the gradient unit,
// hand the tagged result to the Harris response stage, then advance.
module sobel_window_scheduler
   import harris_pkg::*;
#(
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int STEP    = DEF_STEP,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   output logic               frame_busy,
   output logic               frame_done,
   output logic [COORD_W-1:0] win_x,
   output logic [COORD_W-1:0] win_y,
   output logic               win_req,
   input  logic               win_ack,
   output logic               sobel_start,
   input  logic               sobel_q,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [COORD_W-1:0] res_x,
   output logic [COORD_W-1:0] res_y,
   output logic               err_timeout
);

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   sched_state_t       state;
   logic [15:0]        timer;
   logic [COORD_W-1:0] step_x;
   logic [COORD_W-1:0] step_y;
   logic               wrap;
   logic               last;

   window_coord_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .STEP  (STEP)
   ) u_coord (
      .cur_x  (win_x),
      .cur_y  (win_y),
      .step_x (step_x),
      .step_y (step_y),
      .wrap   (wrap),
      .last   (last)
   );

   // Outputs are set on the transition into the state that owns them, so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         win_x       <= '0;
         win_y       <= '0;
         res_x       <= '0;
         res_y       <= '0;
         frame_busy  <= 1'b0;
         frame_done  <= 1'b0;
         win_req     <= 1'b0;
         sobel_start <= 1'b0;
         res_valid   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  win_x       <= '0;
                  win_y       <= '0;
                  err_timeout <= 1'b0;
                  frame_busy  <= 1'b1;
                  win_req     <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               if (win_ack) begin
                  win_req     <= 1'b0;
                  sobel_start <= 1'b1;
                  timer       <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (sobel_q) begin
                  sobel_start <= 1'b0;
                  res_valid   <= 1'b1;
                  res_x       <= win_x;
                  res_y       <= win_y;
                  state       <= PRESENT;
               end else if (timer == TIMER_LAST) begin
                  sobel_start <= 1'b0;
                  err_timeout <= 1'b1;
                  frame_done  <= 1'b1;
                  state       <= DONE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            PRESENT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= DRAIN;
               end
            end
            // A done still high from the last window must fall before the next start.
            DRAIN: begin
               if (!sobel_q) begin
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (last) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  if (wrap) begin
                     win_x <= '0;
                     win_y <= step_y;
                  end else begin
                     win_x <= step_x;
                  end
                  win_req <= 1'b1;
                  state   <= FETCH;
               end
            end
            DONE: begin
               frame_busy <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sobel_window_scheduler.md
SOBEL_WINDOW_SCHEDULER -- requirements
Module: sobel_window_scheduler

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels; SHALL be at least 5.
REQ-002 Parameter IMG_H, default 64: image height in pixels; SHALL be at least 5.
REQ-003 Parameter STEP, default 3: window stride in both axes.
REQ-004 Parameter TIMEOUT, default 8: maximum cycles to wait for sobel_q.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 frame_start  in  1  one-cycle request to process one frame.
REQ-008 frame_busy  out  1  high from frame accept until frame end.
REQ-009 frame_done  out  1  one-cycle pulse at frame end.
REQ-010 win_x, win_y  out  16 each  top-left coordinate of the current 5x5 window.
REQ-011 win_req / win_ack  out / in  1 each  window-fetch handshake with the pixel loader.
REQ-012 sobel_start / sobel_q  out / in  1 each  gradient-unit start and done.
REQ-013 res_valid / res_ready  out / in  1 each  result handshake to the Harris response stage.
REQ-014 res_x, res_y  out  16 each  window coordinate tagged to the result.
REQ-015 err_timeout  out  1  sticky error flag.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, FETCH, ISSUE, PRESENT, DRAIN, ADVANCE and DONE.
REQ-017 In IDLE, frame_start SHALL load win_x=0 and win_y=0 and move to FETCH on the next cycle.
REQ-018 In FETCH, win_req SHALL be held high; win_ack=1 SHALL move to ISSUE; win_ack outside FETCH SHALL be ignored.
REQ-019 In ISSUE, sobel_start SHALL be held high until sobel_q=1, then go to PRESENT with sobel_start=0 from the next cycle.
REQ-020 The ISSUE wait SHALL tolerate the gradient unit's alternate-cycle sampling, i.e. sobel_q arriving 1 or 2 cycles after sobel_start rises.
REQ-021 If sobel_q is not seen within TIMEOUT cycles of entering ISSUE, the block SHALL set err_timeout, drop sobel_start and go to DONE.
REQ-022 In PRESENT, res_valid SHALL be high, with res_x/res_y equal to the issued win_x/win_y and stable until res_ready=1.
REQ-023 The transfer SHALL complete on the cycle where res_valid=1 and res_ready=1, then go to DRAIN.
REQ-024 DRAIN SHALL wait for sobel_q=0 before ADVANCE, so that no start overlaps a stale done; DRAIN is exempt from the timeout.
REQ-025 ADVANCE, x step: if win_x+5 < IMG_W, set win_x = min(win_x+STEP, IMG_W-5).
REQ-026 ADVANCE, row wrap: otherwise set win_x=0 and step win_y the same way with IMG_H.
REQ-027 ADVANCE, frame end: if the window was already the last (x and y both at IMG-5 limits), go to DONE; else go to FETCH.
REQ-028 Clamping SHALL yield a final non-stride window when (IMG-5) is not a multiple of STEP, and no window SHALL be visited twice.
REQ-029 DONE SHALL pulse frame_done for one cycle, then return to IDLE; frame_busy SHALL be high in every state except IDLE.
REQ-030 frame_start while busy SHALL be ignored; err_timeout SHALL clear only on rst or on an accepted frame_start.
REQ-031 Coordinate arithmetic SHALL be unsigned 16-bit; STEP SHALL never push win_x or win_y beyond the IMG-5 limit.

Reset
REQ-032 rst SHALL force IDLE; win_x, win_y, res_x and res_y to 0; all other outputs to 0.
REQ-033 rst SHALL take priority over every other input in the same cycle, including mid-frame; no frame_done SHALL be emitted for an aborted frame.

Structure
REQ-034 Package harris_pkg SHALL hold the state enum, COORD_W=16, WIN=5 and the default parameter values.
REQ-035 The coordinate stepping and clamping SHALL be a sub-module named window_coord_gen (step, wrap and last flags); the FSM stays in the top module.

Verification
REQ-036 IMG_W=11, IMG_H=5, ready and ack always high: x order 0,3,6 at y=0; exactly 3 results; one frame_done.
REQ-037 IMG_W=12, IMG_H=12: x and y each visit 0,3,6,7; exactly 16 results; the clamped window at 7 is present.
REQ-038 res_ready low for 10 cycles: res_valid, res_x and res_y held constant; sobel_start stays 0; no advance.
REQ-039 Model the gradient unit with sobel_q never rising, TIMEOUT=8: err_timeout=1 exactly 8 cycles after ISSUE entry, then frame_done; next frame_start clears it.
REQ-040 rst asserted during PRESENT of the 2nd window: next cycle is IDLE with all outputs 0; no frame_done.
REQ-041 frame_start pulsed during FETCH: ignored; the frame completes with the normal window count.
